// File: rtl/dma_pkg.sv
// Constants and FSM encoding shared by the DMA read and write AXI masters.
package dma_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] PAGE_4KB       = 32'h1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } dma_state_t;

endpackage

// File: rtl/axi_burst_calc.sv
// Sizes the next INCR burst: limited by bytes left, the burst cap and the
// distance to the next 4KB page boundary.
module axi_burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned MAX_BURST_BYTES = 256
) (
  input  logic [11:0] page_offset,
  input  logic [31:0] remaining,
  output logic [31:0] bytes,
  output logic [7:0]  awlen
);

  logic [31:0] page_left;

  always_comb begin
    page_left = PAGE_4KB - {20'd0, page_offset};
    bytes     = remaining;
    if (bytes > 32'(MAX_BURST_BYTES)) bytes = 32'(MAX_BURST_BYTES);
    if (bytes > page_left)            bytes = page_left;
    awlen     = 8'((bytes >> 2) - 32'd1);
  end

endmodule

// File: rtl/axi_write_master.sv
// DMA write side: drains FIFO words into memory as a series of AXI4 INCR
// bursts, one burst in flight at a time (AW, then W beats, then B).
module axi_write_master
  import dma_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_MAX_BURST_BYTES  = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_dst_addr,
  input  logic [31:0]                     i_total_len,
  output logic                            o_write_done,
  output logic                            o_write_error,
  input  logic                            i_fifo_empty,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_fifo_data,
  output logic                            o_fifo_pop,
  output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  dma_state_t                    state_reg;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]                   remain_reg;
  logic [8:0]                    beat_reg;
  logic                          awvalid_reg;
  logic                          bready_reg;
  logic                          done_reg;
  logic                          error_reg;

  logic [31:0] burst_bytes;
  logic [7:0]  burst_awlen;
  logic        w_hs;

  // Length is counted in whole words; the byte remainder is dropped.
  logic unused_len_bits;
  assign unused_len_bits = &{1'b0, i_total_len[1:0]};

  // addr/remaining are frozen from ADDR through RESP, so the sizing seen at
  // the AW handshake is the same one applied when the B response arrives.
  axi_burst_calc #(
    .MAX_BURST_BYTES(C_MAX_BURST_BYTES)
  ) u_burst_calc (
    .page_offset(addr_reg[11:0]),
    .remaining  (remain_reg),
    .bytes      (burst_bytes),
    .awlen      (burst_awlen)
  );

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awlen   = burst_awlen;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = awvalid_reg;

  // W follows the FIFO head directly (first-word-fall-through).
  assign m_axi_wvalid = (state_reg == ST_DATA) && !i_fifo_empty;
  assign m_axi_wdata  = i_fifo_data;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = (state_reg == ST_DATA) && (beat_reg == 9'd1);
  assign w_hs         = m_axi_wvalid && m_axi_wready;
  assign o_fifo_pop   = w_hs;

  assign m_axi_bready  = bready_reg;
  assign o_write_done  = done_reg;
  assign o_write_error = error_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      remain_reg  <= '0;
      beat_reg    <= '0;
      awvalid_reg <= 1'b0;
      bready_reg  <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            error_reg <= 1'b0;
            if (i_total_len[31:2] == 30'd0) begin
              done_reg <= 1'b1;
            end else begin
              done_reg    <= 1'b0;
              addr_reg    <= i_dst_addr;
              remain_reg  <= {i_total_len[31:2], 2'b00};
              awvalid_reg <= 1'b1;
              state_reg   <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (m_axi_awready) begin
            awvalid_reg <= 1'b0;
            beat_reg    <= {1'b0, burst_awlen} + 9'd1;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            beat_reg <= beat_reg - 9'd1;
            if (beat_reg == 9'd1) begin
              bready_reg <= 1'b1;
              state_reg  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (m_axi_bvalid) begin
            bready_reg <= 1'b0;
            addr_reg   <= addr_reg + C_M_AXI_ADDR_WIDTH'(burst_bytes);
            remain_reg <= remain_reg - burst_bytes;
            if (m_axi_bresp != AXI_RESP_OKAY) error_reg <= 1'b1;
            if (remain_reg == burst_bytes) begin
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              awvalid_reg <= 1'b1;
              state_reg   <= ST_ADDR;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_master.sv
// Bench for axi_write_master: FIFO + AXI slave models, burst plan derived
// from the 256B / 4KB splitting rules, randomized readiness and data.
module tb_axi_write_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_dst_addr = '0;
  logic [31:0] i_total_len = '0;
  logic        o_write_done, o_write_error;
  logic        i_fifo_empty = 1'b1;
  logic [31:0] i_fifo_data = '0;
  logic        o_fifo_pop;
  logic [0:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  axi_write_master dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_dst_addr(i_dst_addr),
    .i_total_len(i_total_len), .o_write_done(o_write_done), .o_write_error(o_write_error),
    .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data), .o_fifo_pop(o_fifo_pop),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_w[$];
  logic [31:0] exp_aw_addr[$];
  logic [7:0]  exp_aw_len[$];
  int          beats_left = 0;
  int          pending_b = 0;
  int          burst_idx = 0;
  int          b_wait = 0;
  logic [31:0] slverr_mask = '0;
  int          pops = 0;
  bit          rand_mode = 1'b0;
  int          stall_at = -1;
  int          stall_cycles = 0;
  bit          stall_active = 1'b0;
  bit          f_pop, f_b, f_wlast;
  bit          aw_waiting = 1'b0;
  logic [31:0] prev_awaddr;
  logic [7:0]  prev_awlen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference burst plan: each burst takes as many bytes as the remaining
  // length, the 256B cap and the room left in the current 4KB page allow.
  function automatic int build_plan(input logic [31:0] addr, input logic [31:0] len);
    int unsigned a, rem, b, room, n;
    a = addr; rem = len & ~32'd3; n = 0;
    while (rem > 0) begin
      room = 4096 - (a % 4096);
      b = rem;
      if (b > 256) b = 256;
      if (b > room) b = room;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(8'(b / 4 - 1));
      a += b; rem -= b; n++;
    end
    return n;
  endfunction

  // Monitor: sample just before the edge on which handshakes complete.
  always @(negedge clk) begin
    f_pop = 1'b0; f_b = 1'b0; f_wlast = 1'b0;
    if (!reset) begin
      if (aw_waiting) begin
        check("aw_stable_valid", m_axi_awvalid, 1);
        check("aw_stable_addr", m_axi_awaddr, prev_awaddr);
        check("aw_stable_len", m_axi_awlen, prev_awlen);
      end
      aw_waiting  = m_axi_awvalid && !m_axi_awready;
      prev_awaddr = m_axi_awaddr;
      prev_awlen  = m_axi_awlen;
      if (m_axi_awvalid && m_axi_awready) begin
        check("aw_overlap", {32'(beats_left), 32'(pending_b)}, 0);
        if (exp_aw_addr.size() == 0) check("aw_extra", 1, 0);
        else begin
          check("aw_addr", m_axi_awaddr, exp_aw_addr.pop_front());
          check("aw_len", m_axi_awlen, exp_aw_len[0]);
          beats_left = int'(exp_aw_len.pop_front()) + 1;
          check("aw_const", {m_axi_awsize, m_axi_awburst, m_axi_awid}, {3'b010, 2'b01, 1'b0});
        end
      end
      if (i_fifo_empty) check("wvalid_empty", m_axi_wvalid, 0);
      if (m_axi_wvalid && m_axi_wready) begin
        check("pop_hs", o_fifo_pop, 1);
        check("wstrb", m_axi_wstrb, 4'hF);
        if (exp_w.size() == 0) check("w_extra", 1, 0);
        else check("wdata", m_axi_wdata, exp_w.pop_front());
        check("wlast", m_axi_wlast, beats_left == 1);
        if (beats_left == 1) f_wlast = 1'b1;
        if (beats_left > 0) beats_left--;
        f_pop = 1'b1;
      end else if (o_fifo_pop) begin
        check("pop_no_hs", o_fifo_pop, 0);
      end
      if (m_axi_bvalid && m_axi_bready) f_b = 1'b1;
    end
  end

  // FIFO and slave driver: apply last cycle's handshakes, draw new readiness.
  always @(posedge clk) begin
    #1;
    if (f_pop) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops++;
    end
    if (f_wlast) pending_b++;
    if (f_b) begin
      m_axi_bvalid = 1'b0;
      pending_b--;
      burst_idx++;
    end
    f_pop = 1'b0; f_wlast = 1'b0; f_b = 1'b0;
    if (stall_at >= 0 && pops == stall_at && stall_cycles < 5) begin
      stall_active = 1'b1;
      stall_cycles++;
    end else begin
      stall_active = rand_mode && ($urandom_range(0, 3) == 0);
    end
    m_axi_wready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_awready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!m_axi_bvalid && pending_b > 0) begin
      if (b_wait > 0) b_wait--;
      else begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (burst_idx < 32 && slverr_mask[burst_idx]) ? 2'b10 : 2'b00;
        b_wait       = rand_mode ? $urandom_range(0, 3) : 0;
      end
    end
    i_fifo_empty = (fifo_q.size() == 0) || stall_active;
    i_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
  end

  task automatic start_pulse(input logic [31:0] addr, input logic [31:0] len);
    @(posedge clk); #2;
    i_dst_addr = addr; i_total_len = len; i_start = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
  endtask

  task automatic run_transfer(input logic [31:0] addr, input logic [31:0] len,
                              input logic [31:0] mask, input bit rmode, input int stall);
    int nb, words, cyc;
    bit exp_err;
    nb = build_plan(addr, len);
    words = int'(len >> 2);
    for (int i = 0; i < words; i++) begin
      logic [31:0] w;
      w = $urandom();
      fifo_q.push_back(w);
      exp_w.push_back(w);
    end
    exp_err = 1'b0;
    for (int i = 0; i < nb && i < 32; i++) if (mask[i]) exp_err = 1'b1;
    slverr_mask = mask; rand_mode = rmode; stall_at = stall;
    stall_cycles = 0; burst_idx = 0; pops = 0;
    start_pulse(addr, len);
    @(negedge clk);
    if (nb == 0) begin
      check("len0_done", o_write_done, 1);
      check("len0_no_aw", m_axi_awvalid, 0);
    end else begin
      check("start_done_clr", o_write_done, 0);
      check("start_err_clr", o_write_error, 0);
      check("aw_rise", m_axi_awvalid, 1);
      cyc = 0;
      while (!o_write_done && cyc < 20000) begin
        @(negedge clk);
        cyc++;
      end
      check("timeout", cyc < 20000, 1);
      check("done", o_write_done, 1);
      check("error", o_write_error, exp_err);
      check("aw_left", exp_aw_addr.size(), 0);
      check("w_left", exp_w.size(), 0);
      check("pops", pops, words);
      check("fifo_left", fifo_q.size(), 0);
      check("b_left", pending_b, 0);
      check("idle_awvalid", m_axi_awvalid, 0);
    end
    $display("xfer addr=%08h len=%0d bursts=%0d err=%0b done=%0b", addr, len, nb,
             o_write_error, o_write_done);
    rand_mode = 1'b0; stall_at = -1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_fifo_pop,
                          o_write_done, o_write_error}, 6'b0);

    run_transfer(32'h0000_0000, 32'd0, 0, 1'b0, -1);
    run_transfer(32'h0000_1000, 32'd64, 0, 1'b0, -1);
    run_transfer(32'h0000_0FF0, 32'd64, 0, 1'b0, -1);
    run_transfer(32'h0000_0000, 32'd600, 0, 1'b0, -1);
    run_transfer(32'h0000_2000, 32'd256, 0, 1'b1, 5);
    run_transfer(32'h0000_0F80, 32'd256, 32'h1, 1'b0, -1);
    run_transfer(32'h0000_3000, 32'd16, 0, 1'b0, -1);
    for (int t = 0; t < 10; t++) begin
      logic [31:0] a, l;
      a = {18'd0, 14'($urandom_range(0, 16383))} & ~32'd3;
      l = $urandom_range(0, 1100);
      run_transfer(a, l, $urandom() & 32'h7, 1'b1, -1);
    end

    // Reset while W beats are flowing, then a clean transfer.
    void'(build_plan(32'h0000_4000, 32'd128));
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = $urandom();
      fifo_q.push_back(w);
      exp_w.push_back(w);
    end
    pops = 0;
    start_pulse(32'h0000_4000, 32'd128);
    cyc = 0;
    while (pops < 3 && cyc < 200) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("rst_reach_data", pops >= 3, 1);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    fifo_q.delete(); exp_w.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
    beats_left = 0; pending_b = 0; m_axi_bvalid = 1'b0; burst_idx = 0;
    aw_waiting = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, o_fifo_pop,
                             o_write_done, o_write_error}, 6'b0);
    $display("xfer mid-data reset applied");
    repeat (3) @(negedge clk);
    check("midrst_quiet", m_axi_awvalid, 0);
    run_transfer(32'h0000_5FC0, 32'd200, 0, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
